// File: rtl/frame_reader_pkg.sv
// Shared constants and FSM state encoding for the frame reader.
package frame_reader_pkg;
  localparam int ADDR_W  = 8;
  localparam int COORD_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/frame_reader_pix_fifo2.sv
// Two-entry pixel FIFO carrying the pixel value with its X/Y/Last tags.
module pix_fifo2
  import frame_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_last,
  output logic [DATA_W-1:0]  o_data,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last,
  output logic [1:0]         o_count
);
  localparam int ENT_W = DATA_W + 2 * COORD_W + 1;

  logic [ENT_W-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic [ENT_W-1:0] w_head;

  // A push into a full FIFO or a pop from an empty one is dropped rather than corrupting state.
  assign w_do_push = i_push && (r_count != 2'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= {i_last, i_y, i_x, i_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign o_data  = w_head[DATA_W-1:0];
  assign o_x     = w_head[DATA_W +: COORD_W];
  assign o_y     = w_head[DATA_W + COORD_W +: COORD_W];
  assign o_last  = w_head[ENT_W-1];
  assign o_count = r_count;
endmodule

// File: rtl/frame_reader.sv
// Raster-scans a 16x16 frame memory and streams pixels with coordinates.
// PixValid/PixReady: a pixel transfers in any cycle where both are high; while PixValid is high and PixReady is low, the pixel and its tags are held unchanged.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               ENB,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  output logic               RdEn,
  output logic [ADDR_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  RdData,
  output logic               PixValid,
  input  logic               PixReady,
  output logic [DATA_W-1:0]  PixData,
  output logic [COORD_W-1:0] PixX,
  output logic [COORD_W-1:0] PixY,
  output logic               PixLast,
  output logic [1:0]         o_state
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_tag_addr;
  logic              r_inflight;
  logic              r_done;
  logic              w_rden;
  logic              w_pop;
  logic              w_room;
  logic [1:0]        w_count;
  logic              w_head_last;

  assign w_pop = PixValid && PixReady;
  // Slots already committed (stored + in flight) minus this cycle's pop must leave room.
  assign w_room = (({1'b0, w_count} + {2'b0, r_inflight}) - {2'b0, w_pop}) < 3'(FIFO_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_rden      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start && ENB && !r_done) begin
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_rden = ENB && w_room;
        if (w_rden && (r_addr == LAST_ADDR)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_tag_addr <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rden;
      r_done     <= (r_state == DRAIN) && w_pop && w_head_last;
      if (w_rden) begin
        r_tag_addr <= r_addr;
        r_addr     <= r_addr + 1'b1;
      end
    end
  end

  pix_fifo2 #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (RdData),
    .i_x     (r_tag_addr[COORD_W-1:0]),
    .i_y     (r_tag_addr[ADDR_W-1:COORD_W]),
    .i_last  (r_tag_addr == LAST_ADDR),
    .o_data  (PixData),
    .o_x     (PixX),
    .o_y     (PixY),
    .o_last  (w_head_last),
    .o_count (w_count)
  );

  assign PixValid = (w_count != 2'd0);
  assign PixLast  = w_head_last;
  assign RdEn     = w_rden;
  assign Addr     = r_addr;
  assign Busy     = (r_state != IDLE);
  assign Done     = r_done;
  assign o_state  = r_state;
endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: scenario table plus a pixel scoreboard.
module tb_frame_reader;
  import frame_reader_pkg::*;

  localparam int DATA_W = 8;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              ENB;
  logic              Start;
  logic              PixReady;
  logic              Busy;
  logic              Done;
  logic              RdEn;
  logic              PixValid;
  logic              PixLast;
  logic [7:0]        Addr;
  logic [DATA_W-1:0] RdData;
  logic [DATA_W-1:0] PixData;
  logic [3:0]        PixX;
  logic [3:0]        PixY;
  logic [1:0]        dbg_state;

  frame_reader #(.DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .Start(Start),
    .Busy(Busy), .Done(Done), .RdEn(RdEn), .Addr(Addr), .RdData(RdData),
    .PixValid(PixValid), .PixReady(PixReady), .PixData(PixData),
    .PixX(PixX), .PixY(PixY), .PixLast(PixLast), .o_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Frame memory holds mem[a] = a, data valid the cycle after RdEn.
  always @(posedge ACLK) if (RdEn) RdData <= Addr;

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  bit   mon_en = 0;
  int   iss = 0, pops = 0, exp_addr = 0;
  bit   prev_hold = 0;
  logic [7:0] prev_data;
  logic [3:0] prev_x, prev_y;
  logic prev_last;
  bit   seen_valid;
  int   first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, pix_cnt;
  bit   stalling;
  int   stall_pops;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge ACLK) begin
    bit pop_now;
    logic [7:0] e;
    if (mon_en) begin
      pop_now = PixValid && PixReady;
      if (prev_hold)
        check(PixValid && PixData == prev_data && PixX == prev_x && PixY == prev_y &&
              PixLast == prev_last, "stall_stable", PixData, prev_data);
      prev_hold = PixValid && !PixReady;
      prev_data = PixData; prev_x = PixX; prev_y = PixY; prev_last = PixLast;
      if (RdEn) begin
        check(ENB, "rden_without_enb", ENB, 1);
        check(iss + 1 - pops - int'(pop_now) <= 2, "outstanding", iss + 1 - pops - int'(pop_now), 2);
        check(Addr == exp_addr[7:0], "addr_seq", Addr, exp_addr);
        exp_addr++;
        iss++;
      end
      if (PixValid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check(0, "extra_pixel", PixData, -1);
        end else begin
          e = exp_q.pop_front();
          check(PixData == e, "pix_data", PixData, e);
          check(PixX == e[3:0], "pix_x", PixX, e[3:0]);
          check(PixY == e[7:4], "pix_y", PixY, e[7:4]);
          check(PixLast == (e == 8'd255), "pix_last", PixLast, e == 8'd255);
        end
        pops++;
        pix_cnt++;
        if (PixLast) last_hs_cyc = cyc;
        if (stalling) stall_pops++;
      end
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
        check(!Busy, "busy_at_done", Busy, 0);
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    int mode;            // 0: ready=1, 1: ready 1,0,0,1, 2: random ready
    int stall_addr;      // ENB dropped when Addr reaches this (-1: never)
    int stall_len;
    bit extra_start;     // pulse Start mid-frame and in the Done cycle
    int reset_at;        // ARESET when this pixel is presented (-1: never)
    bit pre_started;     // Start already driven by the previous scenario
    int exp_pix;
    int exp_done;
    int exp_span;        // last handshake - first valid (-1: skip)
    int exp_stall_pops;  // pixels drained while ENB=0 (-1: skip)
  } vec_t;

  vec_t vecs[6];

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_frame(input vec_t v);
    int k, stall_left, t_start;
    bit stall_used, rst_pend, rst_hit;
    seen_valid = 0; done_cnt = 0; pix_cnt = 0; stall_pops = 0; stalling = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    stall_left = 0; stall_used = 0; rst_pend = 0; rst_hit = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    if (!v.pre_started) begin
      @(posedge ACLK); #1;
      Start = 1; ENB = 1; PixReady = ready_for(v.mode, 0);
    end
    t_start = cyc;
    @(posedge ACLK); #1;
    Start = 0; PixReady = ready_for(v.mode, 1);
    @(negedge ACLK);
    check(RdEn && Addr == 8'd0 && Busy, "first_read", {RdEn, Busy, Addr}, 'h300);
    k = 1;
    while (done_cnt == 0 && !rst_hit && k < 4000) begin
      @(posedge ACLK); #1;
      k++;
      if (rst_pend) begin
        ARESET = 0; Start = 1; ENB = 1; PixReady = 1;
        exp_q.delete(); iss = 0; pops = 0; exp_addr = 0; prev_hold = 0;
        rst_hit = 1;
      end else begin
        Start = v.extra_start && (k == 40 || Done);
        PixReady = ready_for(v.mode, k);
        if (stall_left > 0) begin
          check(Addr == v.stall_addr[7:0], "addr_hold", Addr, v.stall_addr);
          stall_left--;
          if (stall_left == 0) begin
            ENB = 1; stalling = 0;
          end
        end else if (!stall_used && v.stall_addr >= 0 && Busy && Addr == v.stall_addr[7:0]) begin
          ENB = 0; stall_left = v.stall_len; stall_used = 1; stalling = 1;
        end
        if (v.reset_at >= 0 && PixValid && PixData == v.reset_at[7:0]) begin
          ARESET = 1; rst_pend = 1;
        end
      end
    end
    if (done_cnt == 0 && !rst_hit) check(0, "frame_timeout", k, 4000);
    if (rst_hit) begin
      @(negedge ACLK);
      check({Busy, Done, RdEn, PixValid, PixLast} == 5'b0, "rst_flags", {Busy, Done, RdEn, PixValid, PixLast}, 0);
      check(Addr == 8'd0, "rst_addr", Addr, 0);
      check(PixData == '0 && PixX == 4'd0 && PixY == 4'd0, "rst_pix", {PixData, PixX, PixY}, 0);
      check(dbg_state == IDLE, "rst_state", dbg_state, IDLE);
      check(pix_cnt == v.exp_pix, "pix_count_before_rst", pix_cnt, v.exp_pix);
      check(done_cnt == v.exp_done, "done_count", done_cnt, v.exp_done);
      return;
    end
    @(posedge ACLK); #1;
    Start = 0; PixReady = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check({Busy, RdEn, PixValid, Done} == 4'b0, "idle_after_done", {Busy, RdEn, PixValid, Done}, 0);
    end
    check(pix_cnt == v.exp_pix, "pix_count", pix_cnt, v.exp_pix);
    check(done_cnt == v.exp_done, "done_count", done_cnt, v.exp_done);
    check(done_cyc == last_hs_cyc + 1, "done_timing", done_cyc, last_hs_cyc + 1);
    check(first_valid_cyc == t_start + 3, "first_valid", first_valid_cyc, t_start + 3);
    if (v.exp_span >= 0)
      check(last_hs_cyc - first_valid_cyc == v.exp_span, "throughput_span", last_hs_cyc - first_valid_cyc, v.exp_span);
    if (v.exp_stall_pops >= 0)
      check(stall_pops == v.exp_stall_pops, "drain_during_stall", stall_pops, v.exp_stall_pops);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    ARESET = 1; ENB = 0; Start = 0; PixReady = 0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 0;
    @(negedge ACLK);
    check({Busy, Done, RdEn, PixValid, PixLast} == 5'b0, "reset_flags", {Busy, Done, RdEn, PixValid, PixLast}, 0);
    check(Addr == 8'd0, "reset_addr", Addr, 0);
    check(PixData == '0 && PixX == 4'd0 && PixY == 4'd0, "reset_pix", {PixData, PixX, PixY}, 0);
    check(dbg_state == IDLE, "reset_state", dbg_state, IDLE);
    mon_en = 1;

    vecs[0] = '{0, -1,  0, 1'b0, -1, 1'b0, 256, 1, 255, -1};
    vecs[1] = '{1, -1,  0, 1'b0, -1, 1'b0, 256, 1,  -1, -1};
    vecs[2] = '{0, 100, 10, 1'b0, -1, 1'b0, 256, 1,  -1,  2};
    vecs[3] = '{0, -1,  0, 1'b0, 50, 1'b0,  51, 0,  -1, -1};
    vecs[4] = '{0, -1,  0, 1'b0, -1, 1'b1, 256, 1, 255, -1};
    vecs[5] = '{2, -1,  0, 1'b1, -1, 1'b0, 256, 1,  -1, -1};

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the pixel word width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, fixed at 2, meaning the output buffer entries.
REQ-003 The block SHALL have port ACLK, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ARESET, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port ENB, input, width 1: read-issue enable.
REQ-006 The block SHALL have port Start, input, width 1: begin a full-frame scan.
REQ-007 The block SHALL have port Busy, output, width 1: high from scan start until Done.
REQ-008 The block SHALL have port Done, output, width 1: one-cycle pulse when the frame is finished.
REQ-009 The block SHALL have port RdEn, output, width 1: frame-memory read strobe.
REQ-010 The block SHALL have port Addr, output, width 8: frame-memory read address, as {Y[3:0],X[3:0]}.
REQ-011 The block SHALL have port RdData, input, width DATA_W: memory data, valid exactly 1 cycle after RdEn.
REQ-012 The block SHALL have port PixValid, output, width 1: pixel stream valid.
REQ-013 The block SHALL have port PixReady, input, width 1: pixel stream ready.
REQ-014 The block SHALL have ports PixData (output, DATA_W), PixX (output, 4), PixY (output, 4) and PixLast (output, 1): pixel value, its coordinates, and last-pixel flag (address 255).

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and DRAIN.
REQ-016 In IDLE, Start=1 and ENB=1 sampled in cycle T SHALL move the FSM to SCAN in T+1, with RdEn=1 and Addr=0 in T+1; Start SHALL be ignored when Busy=1.
REQ-017 In SCAN, RdEn SHALL be asserted only when ENB=1 and (fifo_count + inflight - pop) < 2, where pop = PixValid & PixReady.
REQ-018 Addr SHALL increment by 1 after each issued read, row-major with X fastest; the issue of address 255 SHALL move the FSM to DRAIN.
REQ-019 RdData SHALL be written into the FIFO in the cycle after its RdEn, together with its X, Y and Last tags; the FIFO SHALL never overflow.
REQ-020 The first PixValid SHALL occur in cycle T+3; with PixReady held at 1 and ENB held at 1, throughput SHALL be 1 pixel per cycle and a frame SHALL take 256 consecutive valid cycles.
REQ-021 Once PixValid=1, PixValid, PixData, PixX, PixY and PixLast SHALL stay stable until PixReady=1.
REQ-022 ENB=0 SHALL block new reads only; in-flight data SHALL still be captured and the output SHALL continue to drain.
REQ-023 In DRAIN, the cycle after the PixLast handshake SHALL assert Done=1 for one cycle, deassert Busy and return the FSM to IDLE.
REQ-024 Start asserted in the same cycle as Done SHALL be ignored; a new frame needs Start in IDLE.
REQ-025 Pixels SHALL be emitted in address order with no loss or duplication under any PixReady or ENB pattern.

Reset
REQ-026 ARESET=1 at a clock edge SHALL force: FSM=IDLE, Addr=0, RdEn=0, Busy=0, Done=0, PixValid=0, PixData=0, PixX=0, PixY=0, PixLast=0, FIFO empty, inflight=0.
REQ-027 Reset mid-scan SHALL discard in-flight RdData, and the block SHALL accept Start in the first cycle after ARESET is deasserted.

Structure
REQ-028 A shared package SHALL hold ADDR_W=8, COORD_W=4, LAST_ADDR=255, and the FSM state enum.
REQ-029 The block SHALL instantiate one sub-module, pix_fifo2: a 2-entry FIFO with data, X, Y and Last fields, and count, push and pop ports.

Verification
REQ-030 Bench SHALL check: Start at T with PixReady=1 and a memory model where mem[a]=a -> PixValid first at T+3, PixData 0..255 on consecutive cycles, PixLast with PixX=15 and PixY=15, Done at the cycle after the last handshake.
REQ-031 Bench SHALL check: PixReady toggling 1,0,0,1 repeatedly -> outputs stable while stalled, 256 pixels in order, RdEn never issued with more than 2 outstanding.
REQ-032 Bench SHALL check: ENB=0 for 10 cycles at address 100 -> no RdEn and Addr held at 100, queued pixels still drained, scan resumes at 100.
REQ-033 Bench SHALL check: ARESET pulse at pixel 50 -> all outputs 0 in the next cycle, then a new Start yields pixel 0 first.
REQ-034 Bench SHALL check: Start pulsed while Busy=1 and in the Done cycle -> ignored, no second frame and no Addr disturbance.
